// File: rtl/menu_pkg.sv
// Shared constants and types for the loader menu character buffer.
package menu_pkg;

    // Character buffer geometry
    localparam int MENU_COLS      = 32;
    localparam int MENU_ROWS      = 28;
    localparam int MENU_CLEAR_COL = 2;

    // Character codes used by the menu painters
    localparam logic [6:0] CH_SPACE  = 7'h20;
    localparam logic [6:0] CH_CURSOR = 7'h3E;
    localparam logic [6:0] CH_DASH   = 7'h2D;

    // BRAM map: character buffer, logo ROM region (rows 28-31), font
    localparam logic [10:0] CHARBUF_BASE = 11'h000;
    localparam logic [10:0] LOGO_BASE    = 11'h380;
    localparam logic [10:0] FONT_BASE    = 11'h400;

    // One write transaction towards the character buffer
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [6:0] ch;
    } menu_wr_t;

    // Increment a round-robin pointer, wrapping at n rather than a power of two
    function automatic int rr_wrap_inc(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

    // Linear BRAM address of a character cell
    function automatic logic [10:0] charbuf_addr(input logic [4:0] y, input logic [4:0] x);
        return CHARBUF_BASE | {1'b0, y, x};
    endfunction

endpackage

// File: rtl/menu_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or
// after ptr (ascending, wrapping at NREQ) receives a one-hot grant.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic found;
    int   idx;

    // Scan from ptr upward and take the first pending request
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_write_arbiter.sv
// Write-port arbiter for the menu character buffer. Round-robin shares the
// port among NREQ painters, runs a priority clear-screen scan, and refuses
// any write whose row lands in the logo region.
module menu_write_arbiter
    import menu_pkg::*;
#(
    parameter int         NREQ       = 3,
    parameter int         COL_START  = MENU_CLEAR_COL,
    parameter int         ROWS       = MENU_ROWS,
    parameter logic [6:0] CLEAR_CHAR = CH_SPACE
) (
    input  logic              wclk,
    input  logic              resetn,
    input  logic              clear,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] req_x,
    input  logic [5*NREQ-1:0] req_y,
    input  logic [7*NREQ-1:0] req_char,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              clear_done,
    output logic              drop,
    output logic              menu_wr,
    output logic [4:0]        menu_x,
    output logic [4:0]        menu_y,
    output logic [6:0]        menu_char
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [4:0] COL_FIRST = 5'(COL_START);
    localparam logic [4:0] COL_LAST  = 5'(MENU_COLS - 1);
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [5:0] ROW_LIMIT = 6'(ROWS);

    logic [0:0]       state_reg;
    logic [4:0]       cx_reg;
    logic [4:0]       cy_reg;
    logic             clear_done_reg;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] rr_ptr_next;

    logic             menu_wr_reg;
    logic             drop_reg;
    menu_wr_t         out_reg;

    logic             arb_en;
    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  arb_grant;
    logic             any_grant;
    logic [PTR_W-1:0] grant_idx;
    menu_wr_t         req_pl [NREQ];
    menu_wr_t         sel_pl;
    logic             sel_in_range;
    logic             clear_write;

    // Unpack the flattened requester payload buses
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_pl[gi] = '{x:  req_x[5*gi +: 5],
                              y:  req_y[5*gi +: 5],
                              ch: req_char[7*gi +: 7]};
    end

    // Requesters are only served from an idle engine that is not being
    // told to clear, and not in the clear_done cycle (busy still high).
    assign arb_en  = resetn && (state_reg == ST_IDLE) && !clear && !clear_done_reg;
    assign arb_req = arb_en ? req : '0;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant)
    );

    assign grant     = arb_grant;
    assign any_grant = |arb_grant;

    // Select the granted payload and its index from the one-hot grant
    always_comb begin
        sel_pl    = '0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_pl    = req_pl[i];
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign sel_in_range = ({1'b0, sel_pl.y} < ROW_LIMIT);
    assign rr_ptr_next  = PTR_W'(rr_wrap_inc(int'(grant_idx), NREQ));
    assign clear_write  = (state_reg == ST_CLEAR) && !clear;

    // Clear engine: mode and scan position; a clear pulse always restarts it
    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            cx_reg         <= COL_FIRST;
            cy_reg         <= 5'd0;
            clear_done_reg <= 1'b0;
        end else begin
            clear_done_reg <= 1'b0;
            if (clear) begin
                state_reg <= ST_CLEAR;
                cx_reg    <= COL_FIRST;
                cy_reg    <= 5'd0;
            end else if (state_reg == ST_CLEAR) begin
                if (cx_reg == COL_LAST) begin
                    cx_reg <= COL_FIRST;
                    if (cy_reg == ROW_LAST) begin
                        state_reg      <= ST_IDLE;
                        cy_reg         <= 5'd0;
                        clear_done_reg <= 1'b1;
                    end else begin
                        cy_reg <= cy_reg + 5'd1;
                    end
                end else begin
                    cx_reg <= cx_reg + 5'd1;
                end
            end
        end
    end

    // Round-robin pointer moves past whoever was granted
    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_reg <= '0;
        end else if (any_grant) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Registered BRAM port: clear writes, granted writes, or a range drop
    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            menu_wr_reg <= 1'b0;
            drop_reg    <= 1'b0;
            out_reg     <= '0;
        end else begin
            menu_wr_reg <= 1'b0;
            drop_reg    <= 1'b0;
            if (clear_write) begin
                menu_wr_reg <= 1'b1;
                out_reg     <= '{x: cx_reg, y: cy_reg, ch: CLEAR_CHAR};
            end else if (any_grant) begin
                if (sel_in_range) begin
                    menu_wr_reg <= 1'b1;
                    out_reg     <= sel_pl;
                end else begin
                    drop_reg <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state_reg == ST_CLEAR) || clear_done_reg;
    assign clear_done = clear_done_reg;
    assign drop       = drop_reg;
    assign menu_wr    = menu_wr_reg;
    assign menu_x     = out_reg.x;
    assign menu_y     = out_reg.y;
    assign menu_char  = out_reg.ch;

endmodule

// File: tb/tb_menu_write_arbiter.sv
// Directed bench for menu_write_arbiter at default parameters (NREQ=3).
module tb_menu_write_arbiter;

    logic        wclk;
    logic        resetn;
    logic        clear;
    logic [2:0]  req;
    logic [14:0] req_x;
    logic [14:0] req_y;
    logic [20:0] req_char;
    logic [2:0]  grant;
    logic        busy;
    logic        clear_done;
    logic        drop;
    logic        menu_wr;
    logic [4:0]  menu_x;
    logic [4:0]  menu_y;
    logic [6:0]  menu_char;

    int checks;
    int errors;
    int exp_q[$];

    menu_write_arbiter dut (
        .wclk       (wclk),
        .resetn     (resetn),
        .clear      (clear),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_char   (req_char),
        .grant      (grant),
        .busy       (busy),
        .clear_done (clear_done),
        .drop       (drop),
        .menu_wr    (menu_wr),
        .menu_x     (menu_x),
        .menu_y     (menu_y),
        .menu_char  (menu_char)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_payload(input int i, input logic [4:0] x, input logic [4:0] y, input logic [6:0] c);
        req_x[5*i +: 5]    = x;
        req_y[5*i +: 5]    = y;
        req_char[7*i +: 7] = c;
    endtask

    // Requester i carries (i+1, i+1, 'A'+i)
    task automatic check_payload(input int i);
        check_val("pl_wr",   32'(menu_wr),   32'd1);
        check_val("pl_x",    32'(menu_x),    32'(i + 1));
        check_val("pl_y",    32'(menu_y),    32'(i + 1));
        check_val("pl_char", 32'(menu_char), 32'(7'h41 + i));
        check_val("pl_drop", 32'(drop),      32'd0);
    endtask

    task automatic run_rr(input logic [2:0] r);
        int prev;
        prev = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge wclk);
            req = r;
            #2;
            check_val("rr_grant", 32'(grant), 32'(1 << exp_q[k]));
            if (prev >= 0) check_payload(prev);
            prev = exp_q[k];
        end
        @(negedge wclk);
        req = 3'b000;
        #2;
        check_val("rr_tail_grant", 32'(grant), 32'd0);
        check_payload(prev);
        $display("[tb] round-robin req=%b: %0d grants", r, exp_q.size());
    endtask

    task automatic pulse_clear();
        @(negedge wclk);
        clear = 1'b1;
        #2;
        check_val("clr_pulse_grant", 32'(grant), 32'd0);
        @(negedge wclk);
        clear = 1'b0;
        #2;
        check_val("clr_start_busy",  32'(busy),    32'd1);
        check_val("clr_start_wr",    32'(menu_wr), 32'd0);
        check_val("clr_start_grant", 32'(grant),   32'd0);
    endtask

    // n consecutive clear writes from (2,0); optionally pulse clear on the last
    task automatic clear_writes(input int n, input bit abort_last, input bit completes);
        for (int k = 0; k < n; k++) begin
            @(negedge wclk);
            if (abort_last && k == n - 1) clear = 1'b1;
            #2;
            check_val("clr_wr",    32'(menu_wr),    32'd1);
            check_val("clr_x",     32'(menu_x),     32'(2 + k % 30));
            check_val("clr_y",     32'(menu_y),     32'(k / 30));
            check_val("clr_char",  32'(menu_char),  32'h20);
            check_val("clr_busy",  32'(busy),       32'd1);
            check_val("clr_grant", 32'(grant),      32'd0);
            check_val("clr_done",  32'(clear_done), 32'(completes && k == n - 1));
        end
        $display("[tb] clear: %0d writes checked", n);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        clear    = 1'b0;
        req      = 3'b111;
        req_x    = '0;
        req_y    = '0;
        req_char = '0;
        for (int i = 0; i < 3; i++) set_payload(i, 5'(i + 1), 5'(i + 1), 7'(7'h41 + i));

        // Reset state, with requests pending
        #12;
        check_val("rst_grant", 32'(grant),      32'd0);
        check_val("rst_wr",    32'(menu_wr),    32'd0);
        check_val("rst_x",     32'(menu_x),     32'd0);
        check_val("rst_y",     32'(menu_y),     32'd0);
        check_val("rst_char",  32'(menu_char),  32'd0);
        check_val("rst_busy",  32'(busy),       32'd0);
        check_val("rst_done",  32'(clear_done), 32'd0);
        check_val("rst_drop",  32'(drop),       32'd0);
        @(negedge wclk);
        req    = 3'b000;
        resetn = 1'b1;
        $display("[tb] reset released");

        // Full clear: 840 writes, clear_done on the last, busy drops after
        pulse_clear();
        clear_writes(840, 1'b0, 1'b1);
        @(negedge wclk);
        #2;
        check_val("clr_end_busy", 32'(busy),       32'd0);
        check_val("clr_end_wr",   32'(menu_wr),    32'd0);
        check_val("clr_end_done", 32'(clear_done), 32'd0);

        // req[0] and req[2] alternate, back-to-back
        exp_q = '{0, 2, 0, 2};
        run_rr(3'b101);

        // All three requesters for nine cycles
        exp_q = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        run_rr(3'b111);

        // Row 28 is the logo region: grant consumed, write dropped
        set_payload(1, 5'd5, 5'd28, 7'h42);
        @(negedge wclk);
        req = 3'b010;
        #2;
        check_val("drop_grant", 32'(grant), 32'b010);
        @(negedge wclk);
        req = 3'b000;
        #2;
        check_val("drop_pulse", 32'(drop),    32'd1);
        check_val("drop_wr",    32'(menu_wr), 32'd0);
        check_val("drop_y",     32'(menu_y),  32'd3);
        check_val("drop_x",     32'(menu_x),  32'd3);
        @(negedge wclk);
        #2;
        check_val("drop_clear", 32'(drop), 32'd0);
        set_payload(1, 5'd2, 5'd2, 7'h42);
        $display("[tb] range drop transaction");

        // Clear restarted at write #100
        pulse_clear();
        clear_writes(100, 1'b1, 1'b0);
        @(negedge wclk);
        clear = 1'b0;
        #2;
        check_val("rst_pass_wr",   32'(menu_wr),    32'd0);
        check_val("rst_pass_busy", 32'(busy),       32'd1);
        check_val("rst_pass_done", 32'(clear_done), 32'd0);
        clear_writes(840, 1'b0, 1'b1);
        @(negedge wclk);
        #2;
        check_val("restart_end_busy", 32'(busy), 32'd0);
        check_val("restart_end_done", 32'(clear_done), 32'd0);

        // clear and req[0] together: clear wins, req[0] served afterwards
        @(negedge wclk);
        clear = 1'b1;
        req   = 3'b001;
        #2;
        check_val("both_grant", 32'(grant), 32'd0);
        @(negedge wclk);
        clear = 1'b0;
        #2;
        check_val("both_busy", 32'(busy), 32'd1);
        clear_writes(840, 1'b0, 1'b1);
        @(negedge wclk);
        #2;
        check_val("both_after_busy",  32'(busy),  32'd0);
        check_val("both_after_grant", 32'(grant), 32'b001);
        @(negedge wclk);
        req = 3'b000;
        #2;
        check_payload(0);
        $display("[tb] clear+req collision transaction");

        // Reset in the middle of a clear
        pulse_clear();
        clear_writes(50, 1'b0, 1'b0);
        req = 3'b001;
        #1;
        resetn = 1'b0;
        #1;
        check_val("midrst_wr",    32'(menu_wr), 32'd0);
        check_val("midrst_busy",  32'(busy),    32'd0);
        check_val("midrst_grant", 32'(grant),   32'd0);
        @(negedge wclk);
        resetn = 1'b1;
        req    = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            #2;
            check_val("post_rst_wr",   32'(menu_wr), 32'd0);
            check_val("post_rst_busy", 32'(busy),    32'd0);
        end
        $display("[tb] mid-clear reset transaction");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
